// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: access size codes,
// FSM state encoding and the wait-state counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WAIT   = 2'b01,
        S_ACCESS = 2'b10,
        S_RESP   = 2'b11
    } state_t;

    localparam int WAIT_W = 4;

    // Sign- or zero-extend a byte (v[7:0]) or halfword (v[15:0]) to 32 bits.
    function automatic logic [31:0] load_extend(input logic [15:0] v,
                                                input logic        is_half,
                                                input logic        uns);
        logic [31:0] r;
        if (is_half) begin
            r = uns ? {16'h0000, v} : {{16{v[15]}}, v};
        end else begin
            r = uns ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store strobes and replication, load lane
// select with sign/zero extension. Halves align on addr[1], words ignore addr.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  strobe,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_shift;
    logic [15:0] half_sel;

    // Lane selection and extension per access size.
    always_comb begin
        byte_shift = rword >> {addr_lo, 3'b000};
        half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
        strobe     = 4'b1111;
        wdata_rep  = wdata;
        rdata_ext  = rword;
        case (size)
            SZ_BYTE: begin
                strobe    = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = load_extend({8'h00, byte_shift[7:0]}, 1'b0, uns);
            end
            SZ_HALF: begin
                strobe    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = load_extend(half_sel, 1'b1, uns);
            end
            default: begin
                strobe    = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Valid/ready data memory with byte/half/word access and configurable wait states.
// Optional DMEM_ERR_EN flags misaligned, reserved-size and out-of-range accesses.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDXW = $clog2(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t             state;
    state_t             state_nxt;
    logic               we_r;
    logic [1:0]         size_r;
    logic               uns_r;
    logic [IDXW+1:0]    addr_r;
    logic [31:0]        wdata_r;
    logic [WAIT_W-1:0]  cnt_r;
    logic [31:0]        rdata_r;
    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               do_access;
    logic               mem_we;
    logic               err;
    logic [IDXW-1:0]    idx;
    logic [31:0]        rword;
    logic [3:0]         strobe;
    logic [31:0]        wdata_rep;
    logic [31:0]        rdata_ext;

    assign idx   = addr_r[IDXW+1:2];
    assign rword = mem[idx];

    dmem_lane_align u_align (
        .size      (size_r),
        .addr_lo   (addr_r[1:0]),
        .uns       (uns_r),
        .wdata     (wdata_r),
        .rword     (rword),
        .strobe    (strobe),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

`ifdef DMEM_ERR_EN
    logic addr_hi_r;
    logic err_r;

    // Out-of-range flag captured with the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_hi_r <= 1'b0;
        end else if (accept) begin
            addr_hi_r <= |req_addr[31:IDXW+2];
        end
    end

    assign err = (size_r == SZ_RSVD)
               || ((size_r == SZ_HALF) && addr_r[0])
               || ((size_r == SZ_WORD) && (addr_r[1:0] != 2'b00))
               || addr_hi_r;

    // Error flag for the pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (do_access) begin
            err_r <= err;
        end
    end

    assign rsp_err = err_r;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDXW+2];
    assign err     = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r == '0) begin
                    state_nxt = S_ACCESS;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register; req_ready stays low while in reset.
    always_comb begin
        req_ready = (state == S_IDLE) && !rst;
        accept    = req_valid && req_ready;
        do_access = (state == S_ACCESS);
        mem_we    = do_access && we_r && !err;
        rsp_valid = (state == S_RESP);
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            size_r  <= SZ_BYTE;
            uns_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            cnt_r   <= '0;
        end else if (accept) begin
            we_r    <= req_we;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            addr_r  <= req_addr[IDXW+1:0];
            wdata_r <= req_wdata;
            cnt_r   <= WAIT_INIT;
        end else if ((state == S_WAIT) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - 1'b1;
        end
    end

    // Response data, loaded in the ACCESS cycle and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if (do_access) begin
            rdata_r <= (we_r || err) ? 32'h0000_0000 : rdata_ext;
        end
    end

    assign rsp_rdata = rdata_r;

    // RAM array with per-lane writes; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule
